// File: rtl/spi_slave_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_cmd_decoder_if
// Description : Byte-side and plug-side signal bundle of the SPI slave command
//               decoder. The slave modport is the decoder's view; the master
//               modport is the view of whatever drives it (SPI front end,
//               plug, or a testbench).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_cmd_decoder_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  // SPI byte front end
  logic                      cs_n;
  logic [7:0]                rx_byte;
  logic                      rx_byte_valid;
  logic [7:0]                tx_byte;
  logic                      tx_byte_valid;
  logic                      tx_byte_ready;
  // APB plug side
  logic [APB_ADDR_WIDTH-1:0] rxtx_addr;
  logic                      rxtx_addr_valid;
  logic [15:0]               wrap_length;
  logic                      start_tx;
  logic                      cs;
  logic [APB_DATA_WIDTH-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic [APB_DATA_WIDTH-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      overflow;

  modport slave (
    input  cs_n, rx_byte, rx_byte_valid, tx_byte_ready, rx_ready, tx_data, tx_valid,
    output tx_byte, tx_byte_valid, rxtx_addr, rxtx_addr_valid, wrap_length,
           start_tx, cs, rx_data, rx_valid, tx_ready, overflow
  );

  modport master (
    output cs_n, rx_byte, rx_byte_valid, tx_byte_ready, rx_ready, tx_data, tx_valid,
    input  tx_byte, tx_byte_valid, rxtx_addr, rxtx_addr_valid, wrap_length,
           start_tx, cs, rx_data, rx_valid, tx_ready, overflow
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_cmd_decoder
// Description : Parses SPI command bytes (opcode, wrap length, address, write
//               data) into APB plug controls and serializes plug read words
//               back into bytes for the SPI transmitter. pclk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_cmd_decoder #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
) (
  input  wire logic              pclk,
  input  wire logic              presetn,
  spi_slave_cmd_decoder_if.slave bus
);

  localparam int C_NA = APB_ADDR_WIDTH / 8;
  localparam int C_ND = APB_DATA_WIDTH / 8;
  // Shared shift register must hold the widest field (address, data or the 16-bit wrap length)
  localparam int C_AB = (APB_ADDR_WIDTH > APB_DATA_WIDTH) ? APB_ADDR_WIDTH : APB_DATA_WIDTH;
  localparam int C_SW = (C_AB > 16) ? C_AB : 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WRAP   = 3'd2,
    S_ADDR   = 3'd3,
    S_WDATA  = 3'd4,
    S_RDATA  = 3'd5,
    S_IGNORE = 3'd6
  } state_e;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q;
  logic [C_SW-9:0]           asm_q;       // all bytes of a field except the last one
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      addr_valid_q;
  logic [15:0]               wrap_q;
  logic                      start_tx_q;
  logic [APB_DATA_WIDTH-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      overflow_q;
  logic [APB_DATA_WIDTH-1:0] tx_buf_q;
  logic                      tx_full_q;
  logic [7:0]                tx_idx_q;

  logic                      w_byte;
  logic [C_SW-1:0]           w_asm_nxt;
  logic                      w_tx_ready;
  logic                      w_tx_take;
  logic                      w_tx_adv;

  // A byte counts only while selected; a byte coinciding with deselect is dropped
  assign w_byte    = bus.rx_byte_valid && !bus.cs_n;
  assign w_asm_nxt = {asm_q, bus.rx_byte};
  // Outside RDATA read words are always swallowed so the plug never stalls
  assign w_tx_ready = (state_q != S_RDATA) || !tx_full_q;
  assign w_tx_take  = (state_q == S_RDATA) && !bus.cs_n && bus.tx_valid && !tx_full_q;
  assign w_tx_adv   = tx_full_q && bus.tx_byte_ready;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; deselect always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (bus.cs_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (w_byte) begin
            case (bus.rx_byte)
              8'h01:   state_d = S_WRAP;
              8'h02:   state_d = S_ADDR;
              8'h03:   state_d = S_WDATA;
              8'h04:   state_d = S_RDATA;
              default: state_d = S_IGNORE;
            endcase
          end
        end
        S_WRAP:  if (w_byte && cnt_q == 8'd1)          state_d = S_CMD;
        S_ADDR:  if (w_byte && cnt_q == 8'(C_NA - 1))  state_d = S_CMD;
        default: state_d = state_q;
      endcase
    end
  end

  // Field assembly, plug control pulses, write-word handoff and overflow tracking
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= '0;
      start_tx_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      addr_valid_q <= 1'b0;
      start_tx_q   <= 1'b0;
      if (state_q == S_IDLE && !bus.cs_n) overflow_q <= 1'b0;
      // Handshake clear first so a word completing this cycle can re-arm rx_valid
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
      if (bus.cs_n) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else if (w_byte) begin
        case (state_q)
          S_CMD: if (bus.rx_byte == 8'h04) start_tx_q <= 1'b1;
          S_WRAP: begin
            if (cnt_q == 8'd1) begin
              wrap_q <= w_asm_nxt[15:0];
              cnt_q  <= '0;
              asm_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
              asm_q <= w_asm_nxt[C_SW-9:0];
            end
          end
          S_ADDR: begin
            if (cnt_q == 8'(C_NA - 1)) begin
              addr_q       <= w_asm_nxt[APB_ADDR_WIDTH-1:0];
              addr_valid_q <= 1'b1;
              cnt_q        <= '0;
              asm_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
              asm_q <= w_asm_nxt[C_SW-9:0];
            end
          end
          S_WDATA: begin
            if (cnt_q == 8'(C_ND - 1)) begin
              cnt_q <= '0;
              asm_q <= '0;
              if (rx_valid_q && !bus.rx_ready) begin
                overflow_q <= 1'b1;
              end else begin
                rx_data_q  <= w_asm_nxt[APB_DATA_WIDTH-1:0];
                rx_valid_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
              asm_q <= w_asm_nxt[C_SW-9:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read-word buffer: capture one word, shift it out MSB byte first
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
      tx_idx_q  <= '0;
    end else if (bus.cs_n) begin
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
      tx_idx_q  <= '0;
    end else if (w_tx_take) begin
      tx_buf_q  <= bus.tx_data;
      tx_full_q <= 1'b1;
      tx_idx_q  <= '0;
    end else if (w_tx_adv) begin
      if (tx_idx_q == 8'(C_ND - 1)) begin
        tx_buf_q  <= '0;
        tx_full_q <= 1'b0;
        tx_idx_q  <= '0;
      end else begin
        tx_buf_q <= tx_buf_q << 8;
        tx_idx_q <= tx_idx_q + 8'd1;
      end
    end
  end

  assign bus.tx_byte         = tx_buf_q[APB_DATA_WIDTH-1 -: 8];
  assign bus.tx_byte_valid   = tx_full_q;
  assign bus.tx_ready        = w_tx_ready;
  assign bus.rxtx_addr       = addr_q;
  assign bus.rxtx_addr_valid = addr_valid_q;
  assign bus.wrap_length     = wrap_q;
  assign bus.start_tx        = start_tx_q;
  assign bus.cs              = bus.cs_n;
  assign bus.rx_data         = rx_data_q;
  assign bus.rx_valid        = rx_valid_q;
  assign bus.overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_cmd_decoder
// Description : Directed self-checking bench for spi_slave_cmd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_cmd_decoder;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  spi_slave_cmd_decoder_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

  spi_slave_cmd_decoder #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  int         addr_pulses  = 0;
  int         start_pulses = 0;
  int         busy_ready   = 0;
  logic [31:0] rx_words[$];
  logic [7:0]  tx_bytes[$];

  // Event recorders, sampled on the falling edge
  always @(negedge pclk) begin
    if (presetn) begin
      if (bus.rxtx_addr_valid) addr_pulses <= addr_pulses + 1;
      if (bus.start_tx) start_pulses <= start_pulses + 1;
      if (bus.tx_byte_valid && bus.tx_ready) busy_ready <= busy_ready + 1;
      if (bus.rx_valid && bus.rx_ready) rx_words.push_back(bus.rx_data);
      if (bus.tx_byte_valid && bus.tx_byte_ready) tx_bytes.push_back(bus.tx_byte);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte       = b;
    bus.rx_byte_valid = 1'b1;
    tick(1);
    bus.rx_byte_valid = 1'b0;
    tick(2);
  endtask

  int n0;

  initial begin
    presetn           = 1'b0;
    bus.cs_n          = 1'b1;
    bus.rx_byte       = 8'h00;
    bus.rx_byte_valid = 1'b0;
    bus.tx_byte_ready = 1'b0;
    bus.rx_ready      = 1'b0;
    bus.tx_data       = 32'h0;
    bus.tx_valid      = 1'b0;
    tick(3);
    presetn = 1'b1;
    tick(1);

    // Reset state
    check("rst_addr",      bus.rxtx_addr, 64'h0);
    check("rst_addr_vld",  bus.rxtx_addr_valid, 64'h0);
    check("rst_wrap",      bus.wrap_length, 64'h0);
    check("rst_start",     bus.start_tx, 64'h0);
    check("rst_cs",        bus.cs, 64'h1);
    check("rst_rx_data",   bus.rx_data, 64'h0);
    check("rst_rx_valid",  bus.rx_valid, 64'h0);
    check("rst_overflow",  bus.overflow, 64'h0);
    check("rst_txb_valid", bus.tx_byte_valid, 64'h0);
    check("rst_tx_ready",  bus.tx_ready, 64'h1);

    // Address command, then wrap and write data in the same selection
    bus.cs_n = 1'b0;
    tick(2);
    check("cs_low", bus.cs, 64'h0);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check("addr_value",  bus.rxtx_addr, 64'h12345678);
    check("addr_pulses", addr_pulses, 64'd1);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    check("wrap_value", bus.wrap_length, 64'h4);
    bus.rx_ready = 1'b1;
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check("wr_count", rx_words.size(), 64'd2);
    if (rx_words.size() == 2) begin
      check("wr_word0", rx_words[0], 64'h11223344);
      check("wr_word1", rx_words[1], 64'hAABBCCDD);
    end
    check("wr_no_ovf", bus.overflow, 64'h0);
    bus.cs_n = 1'b1;
    tick(2);

    // Write with plug stalled: second word lost, overflow set
    bus.rx_ready = 1'b0;
    bus.cs_n     = 1'b0;
    tick(2);
    send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("stall_valid", bus.rx_valid, 64'h1);
    check("stall_data0", bus.rx_data, 64'h11223344);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check("stall_data1", bus.rx_data, 64'h11223344);
    check("stall_ovf",   bus.overflow, 64'h1);
    bus.cs_n = 1'b1;
    tick(2);
    check("desel_keep_valid", bus.rx_valid, 64'h1);
    check("desel_ovf_sticky", bus.overflow, 64'h1);
    bus.cs_n = 1'b0;
    tick(1);
    check("ovf_cleared", bus.overflow, 64'h0);
    bus.rx_ready = 1'b1;
    tick(1);
    check("pending_drained", bus.rx_valid, 64'h0);
    check("pending_count",   rx_words.size(), 64'd3);
    if (rx_words.size() == 3) check("pending_word", rx_words[2], 64'h11223344);
    bus.cs_n = 1'b1;
    tick(2);

    // Read burst
    bus.cs_n          = 1'b0;
    bus.tx_byte_ready = 1'b1;
    tick(2);
    send_byte(8'h04);
    check("start_pulses", start_pulses, 64'd1);
    check("rd_ready_empty", bus.tx_ready, 64'h1);
    bus.tx_data  = 32'hDEADBEEF;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    check("rd_ready_busy", bus.tx_ready, 64'h0);
    check("rd_first_byte", bus.tx_byte, 64'hDE);
    tick(6);
    check("rd_count", tx_bytes.size(), 64'd4);
    if (tx_bytes.size() == 4)
      check("rd_bytes", {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3]}, 64'hDEADBEEF);
    check("rd_never_ready_busy", busy_ready, 64'd0);
    check("rd_ready_after", bus.tx_ready, 64'h1);
    check("rd_txb_idle",    bus.tx_byte_valid, 64'h0);
    bus.cs_n = 1'b1;
    tick(2);

    // Aborted write followed by a clean one
    bus.cs_n = 1'b0;
    tick(2);
    n0 = rx_words.size();
    send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB);
    bus.cs_n = 1'b1;
    tick(3);
    check("abort_no_word",  rx_words.size(), 64'(n0));
    check("abort_no_valid", bus.rx_valid, 64'h0);
    bus.cs_n = 1'b0;
    tick(2);
    send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("clean_count", rx_words.size(), 64'(n0 + 1));
    if (rx_words.size() == n0 + 1) check("clean_word", rx_words[n0], 64'h01020304);
    bus.cs_n = 1'b1;
    tick(2);

    // Unknown opcode: everything ignored until deselect
    bus.cs_n = 1'b0;
    tick(2);
    send_byte(8'h7F);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    check("ign_addr_pulses", addr_pulses, 64'd1);
    check("ign_addr_kept",   bus.rxtx_addr, 64'h12345678);
    check("ign_no_start",    start_pulses, 64'd1);
    bus.tx_data  = 32'hCAFEF00D;
    bus.tx_valid = 1'b1;
    check("ign_tx_ready", bus.tx_ready, 64'h1);
    tick(1);
    bus.tx_valid = 1'b0;
    tick(1);
    check("ign_txb_idle", bus.tx_byte_valid, 64'h0);
    bus.cs_n = 1'b1;
    tick(2);
    check("wrap_retained", bus.wrap_length, 64'h4);
    check("cs_high",       bus.cs, 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
